// File: rtl/riscv_dmem_io_pkg.sv
// riscv_dmem_io_pkg
// Shared constants and types for the data-side memory/IO block:
//   - IO_SEL_BIT    : address bit that selects the IO page over RAM
//   - OFF_*         : byte offsets (Address[7:0]) of the IO registers
//   - ST_*          : bit positions inside the UART_STATUS word
//   - tx_state_t    : UART transmitter FSM states
//   - rx_state_t    : UART receiver FSM states (used only when UART_RX_EN is defined)
package riscv_dmem_io_pkg;

    localparam int IO_SEL_BIT = 22;

    localparam logic [7:0] OFF_LEDS        = 8'h00;
    localparam logic [7:0] OFF_UART_DATA   = 8'h04;
    localparam logic [7:0] OFF_UART_STATUS = 8'h08;
    localparam logic [7:0] OFF_CYCLE       = 8'h0C;
    localparam logic [7:0] OFF_UART_RX     = 8'h10;

    localparam int ST_BUSY       = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERFLOW   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_COUNT_LSB  = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO feeding an 8N1 serial transmitter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   TX_IDLE  | line high; pops the FIFO head as soon as it is non-empty
//   TX_START | start bit (low) for CLK_DIV cycles
//   TX_DATA  | 8 data bits, LSB first, CLK_DIV cycles each
//   TX_STOP  | stop bit (high) for CLK_DIV cycles, then back to TX_IDLE
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push         enqueue push_data at this edge (dropped when full)
//   push_data    byte to enqueue
//   full         FIFO holds FIFO_DEPTH entries
//   count        current number of queued bytes
//   busy         transmitter active or FIFO non-empty
//   tx           serial line, idle high, registered
module uart_tx_fifo
    import riscv_dmem_io_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          tx
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    tx_state_t     state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;

    // Fullness is taken from the count before the edge, so a push that
    // coincides with a pop on a full FIFO is still dropped.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = (state == TX_IDLE) && (count != '0);
    assign busy    = (state != TX_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TX_IDLE;
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (do_pop) begin
                        shift_reg <= mem[rd_ptr];
                        baud_cnt  <= BAUD_LOAD;
                        tx        <= 1'b0;
                        state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            // Next bit goes out now; shift so shift_reg[0] is the bit on the line.
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_cnt == '0) begin
                        tx    <= 1'b1;
                        state <= TX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_dmem_io.sv
// riscv_dmem_io
// Data-side memory system for the pipelined RV32 core's M stage. Address[22]
// selects word RAM (0) or the IO page (1). ReadData is combinational so the
// core captures it in the same cycle. The IO page holds LEDs, a buffered
// UART transmitter and a free-running cycle counter.
//
// Optional build macro UART_RX_EN adds a uart_rx input, a synchronised 8N1
// receiver with a holding register at offset 0x10 and status bit3 rx_overrun.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   Address      byte address (Address[1:0] ignored, word accesses only)
//   WriteData    store data
//   MemWrite     store strobe
//   ReadData     combinational read data
//   leds         LED register
//   uart_tx      serial TX line, idle high
//   uart_rx      serial RX line (UART_RX_EN builds only)
module riscv_dmem_io
    import riscv_dmem_io_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        uart_tx
`ifdef UART_RX_EN
    ,
    input  logic        uart_rx
`endif
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_io;
    logic [7:0]    io_off;
    logic          io_wr;
    logic          wr_leds;
    logic          wr_uart;
    logic          wr_status;
    logic          wr_cycle;
    logic          unused_addr;

    logic          fifo_full;
    logic          fifo_busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [31:0]   cycle;
    logic [31:0]   status_word;

    assign is_io     = Address[IO_SEL_BIT];
    assign io_off    = Address[7:0];
    assign ram_idx   = Address[AW+1:2];
    assign io_wr     = MemWrite && is_io;
    assign wr_leds   = io_wr && (io_off == OFF_LEDS);
    assign wr_uart   = io_wr && (io_off == OFF_UART_DATA);
    assign wr_status = io_wr && (io_off == OFF_UART_STATUS);
    assign wr_cycle  = io_wr && (io_off == OFF_CYCLE);

    // Upper RAM-side address bits alias by design; byte offset is ignored.
    assign unused_addr = ^Address;

    always_ff @(posedge clk) begin
        if (MemWrite && !is_io) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
        end else if (wr_leds) begin
            leds <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || wr_cycle) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    // A dropped push always sets overflow, even if the status write in some
    // later cycle would clear it; the two can never hit the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_uart && fifo_full) begin
            overflow <= 1'b1;
        end else if (wr_status && WriteData[ST_OVERFLOW]) begin
            overflow <= 1'b0;
        end
    end

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_uart),
        .push_data (WriteData[7:0]),
        .full      (fifo_full),
        .count     (fifo_count),
        .busy      (fifo_busy),
        .tx        (uart_tx)
    );

`ifdef UART_RX_EN
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] RX_FULL = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] RX_HALF = BW'(CLK_DIV / 2 - 1);

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    rx_state_t     rx_state;
    logic [BW-1:0] rx_baud;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_overrun;
    logic          wr_rx;

    assign wr_rx = io_wr && (io_off == OFF_UART_RX);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_baud    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (wr_rx) begin
                rx_valid <= 1'b0;
            end
            if (wr_status && WriteData[ST_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_baud  <= RX_HALF;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud == '0) begin
                        // Start bit must still be low at mid-bit, else it was a glitch.
                        if (!rx_s2) begin
                            rx_baud  <= RX_FULL;
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_baud  <= RX_FULL;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud == '0) begin
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !wr_rx) begin
                                rx_overrun <= 1'b1;
                            end
                        end
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
`endif

    always_comb begin
        status_word                       = '0;
        status_word[ST_BUSY]              = fifo_busy;
        status_word[ST_FULL]              = fifo_full;
        status_word[ST_OVERFLOW]          = overflow;
        status_word[ST_COUNT_LSB +: 4]    = 4'(fifo_count);
`ifdef UART_RX_EN
        status_word[ST_RX_OVERRUN]        = rx_overrun;
`endif
    end

    always_comb begin
        ReadData = '0;
        if (!is_io) begin
            ReadData = ram[ram_idx];
        end else begin
            case (io_off)
                OFF_LEDS:        ReadData = {24'b0, leds};
                OFF_UART_STATUS: ReadData = status_word;
                OFF_CYCLE:       ReadData = cycle;
`ifdef UART_RX_EN
                OFF_UART_RX:     ReadData = {23'b0, rx_valid, rx_data};
`endif
                default:         ReadData = '0;
            endcase
        end
    end

endmodule
